// File: rtl/rapid_pkg.sv
// Shared core constants and types for the integer register file.
// Holds the data width, stack-pointer reset value and register-index helpers.
package rapid_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_STACK_POINTER = 32'h0000_8000;

  localparam int REG_ADDR_W = 5;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam int REG_ZERO = 0;
  localparam int REG_SP   = 2;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy vector: allocation sets a bit, writeback clears it.
// Built only when REGFILE_SCOREBOARD_EN is defined.
module regfile_scoreboard
#(
  parameter  int NUM_REGS = 32,
  parameter  int NUM_WR   = 1,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_alloc_en,
  input  logic [AW-1:0]          i_alloc_addr,
  input  logic [NUM_WR-1:0]      i_wr_en,
  input  logic [NUM_WR*AW-1:0]   i_wr_addr,
  output logic [NUM_REGS-1:0]    o_busy
);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_busy <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (i_wr_en[w]) o_busy[i_wr_addr[w*AW +: AW]] <= 1'b0;
      end
      // Applied after the clears so a same-cycle alloc (the new owner) wins.
      if (i_alloc_en && i_alloc_addr != '0) o_busy[i_alloc_addr] <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with same-cycle write-to-read bypass.
// Define REGFILE_SCOREBOARD_EN to build the RAW-hazard busy scoreboard.
module regfile_mp
#(
  parameter  int                   XLEN     = rapid_pkg::XLEN,
  parameter  int                   NUM_REGS = 32,
  parameter  int                   NUM_RD   = 2,
  parameter  int                   NUM_WR   = 1,
  parameter  logic [XLEN-1:0]      SP_RESET = rapid_pkg::RESET_STACK_POINTER,
  localparam int                   AW       = $clog2(NUM_REGS)
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic [NUM_RD-1:0]        i_rs_en,
  input  logic [NUM_RD*AW-1:0]     i_rs_addr,
  output logic [NUM_RD*XLEN-1:0]   o_rs_data,
  output logic [NUM_RD-1:0]        o_rs_ready,
  input  logic [NUM_WR-1:0]        i_wr_en,
  input  logic [NUM_WR*AW-1:0]     i_wr_addr,
  input  logic [NUM_WR*XLEN-1:0]   i_wr_data,
  input  logic                     i_alloc_en,
  input  logic [AW-1:0]            i_alloc_addr,
  output logic [NUM_REGS-1:0]      o_busy
);

  import rapid_pkg::*;

  logic [XLEN-1:0]     regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      // NOTE: every entry needs a defined reset value (r2 = stack pointer),
      // so the array is flops with a reset, not an inferred RAM.
      for (int r = 0; r < NUM_REGS; r++) begin
        regs[r] <= (r == REG_SP) ? SP_RESET : '0;
      end
    end else begin
      // NOTE: non-blocking updates let a later loop iteration override an
      // earlier one, so the highest-index write port wins on a collision.
      for (int w = 0; w < NUM_WR; w++) begin
        if (i_wr_en[w] && i_wr_addr[w*AW +: AW] != '0) begin
          regs[i_wr_addr[w*AW +: AW]] <= i_wr_data[w*XLEN +: XLEN];
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0]   addr;
    logic            hit;
    logic [XLEN-1:0] byp_data;

    assign addr = i_rs_addr[p*AW +: AW];

    always_comb begin
      // NOTE: defaults first so every path assigns hit/byp_data (no latch).
      hit      = 1'b0;
      byp_data = '0;
      for (int w = 0; w < NUM_WR; w++) begin
        if (i_wr_en[w] && i_wr_addr[w*AW +: AW] == addr && addr != '0) begin
          hit      = 1'b1;
          byp_data = i_wr_data[w*XLEN +: XLEN];
        end
      end
    end

    assign o_rs_data[p*XLEN +: XLEN] = !i_rs_en[p]  ? '0       :
                                       hit          ? byp_data :
                                       (addr == '0) ? '0       : regs[addr];
    assign o_rs_ready[p] = i_rs_en[p] && (!busy[addr] || hit || addr == '0);
  end

`ifdef REGFILE_SCOREBOARD_EN
  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_WR   (NUM_WR)
  ) u_scoreboard (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_alloc_en   (i_alloc_en),
    .i_alloc_addr (i_alloc_addr),
    .i_wr_en      (i_wr_en),
    .i_wr_addr    (i_wr_addr),
    .o_busy       (busy)
  );
`else
  // Without the scoreboard nothing is ever in flight; allocs have no effect.
  logic unused_alloc;
  assign unused_alloc = &{1'b0, i_alloc_en, i_alloc_addr};
  assign busy = '0;
`endif

  assign o_busy = busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (2 read, 2 write ports); expectations are
// queued by the stimulus and checked by an independent negedge monitor.
module tb_regfile_mp;

  localparam int          XLEN  = 32;
  localparam int          NREGS = 32;
  localparam int          NRD   = 2;
  localparam int          NWR   = 2;
  localparam int          AW    = 5;
  localparam logic [31:0] SP    = 32'h0000_7FF0;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [NRD-1:0]        rs_en;
  logic [NRD*AW-1:0]     rs_addr;
  logic [NRD*XLEN-1:0]   rs_data;
  logic [NRD-1:0]        rs_ready;
  logic [NWR-1:0]        wr_en;
  logic [NWR*AW-1:0]     wr_addr;
  logic [NWR*XLEN-1:0]   wr_data;
  logic                  alloc_en;
  logic [AW-1:0]         alloc_addr;
  logic [NREGS-1:0]      busy;

  regfile_mp #(
    .XLEN     (XLEN),
    .NUM_REGS (NREGS),
    .NUM_RD   (NRD),
    .NUM_WR   (NWR),
    .SP_RESET (SP)
  ) dut (
    .i_clk        (clk),
    .i_reset_n    (reset_n),
    .i_rs_en      (rs_en),
    .i_rs_addr    (rs_addr),
    .o_rs_data    (rs_data),
    .o_rs_ready   (rs_ready),
    .i_wr_en      (wr_en),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data),
    .i_alloc_en   (alloc_en),
    .i_alloc_addr (alloc_addr),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       name;
    bit          is_busy;
    int          port;
    logic [31:0] data;
    logic        ready;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic idle();
    rs_en      = '0;
    rs_addr    = '0;
    wr_en      = '0;
    wr_addr    = '0;
    wr_data    = '0;
    alloc_en   = 1'b0;
    alloc_addr = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic rd(input int p, input int a);
    rs_en[p]           = 1'b1;
    rs_addr[p*AW +: AW] = a[AW-1:0];
  endtask

  task automatic wr(input int w, input int a, input logic [31:0] d);
    wr_en[w]               = 1'b1;
    wr_addr[w*AW +: AW]     = a[AW-1:0];
    wr_data[w*XLEN +: XLEN] = d;
  endtask

  task automatic alloc(input int a);
    alloc_en   = 1'b1;
    alloc_addr = a[AW-1:0];
  endtask

  task automatic exp_rd(input string name, input int p, input logic [31:0] d, input logic r);
    exp_t e;
    e.cyc = cyc; e.name = name; e.is_busy = 1'b0; e.port = p; e.data = d; e.ready = r;
    q.push_back(e);
  endtask

  task automatic exp_busy(input string name, input logic [31:0] b);
    exp_t e;
    e.cyc = cyc; e.name = name; e.is_busy = 1'b1; e.port = 0; e.data = b; e.ready = 1'b0;
    q.push_back(e);
  endtask

  // Monitor: consumes every expectation tagged with the current cycle.
  initial begin
    exp_t        e;
    logic [31:0] got;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        total++;
        if (e.cyc < cyc) begin
          bad++;
          $display("FAIL %s: expectation for cycle %0d not checked until cycle %0d", e.name, e.cyc, cyc);
        end else if (e.is_busy) begin
          got = busy;
          if (got !== e.data) begin
            bad++;
            $display("FAIL %s: busy=%h expected %h", e.name, got, e.data);
          end
        end else begin
          got = rs_data[e.port*XLEN +: XLEN];
          if (got !== e.data || rs_ready[e.port] !== e.ready) begin
            bad++;
            $display("FAIL %s: port%0d data=%h ready=%b expected data=%h ready=%b",
                     e.name, e.port, got, rs_ready[e.port], e.data, e.ready);
          end
        end
      end
    end
  end

  initial begin
    int waited;
    reset_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Post-reset contents: zero everywhere except r2.
    for (int r = 0; r < NREGS; r += 2) begin
      step();
      rd(0, r);
      rd(1, r + 1);
      exp_rd($sformatf("reset_r%0d", r), 0, (r == 2) ? SP : 32'h0, 1'b1);
      exp_rd($sformatf("reset_r%0d", r + 1), 1, 32'h0, 1'b1);
      if (r == 0) exp_busy("reset_busy", 32'h0);
    end

    // Same-cycle bypass, then array read.
    step();
    wr(0, 5, 32'hDEAD_BEEF);
    rd(0, 5);
    rd(1, 5);
    exp_rd("bypass_r5_p0", 0, 32'hDEAD_BEEF, 1'b1);
    exp_rd("bypass_r5_p1", 1, 32'hDEAD_BEEF, 1'b1);
    step();
    rd(0, 5);
    rs_addr[AW +: AW] = 5'd5;
    exp_rd("array_r5", 0, 32'hDEAD_BEEF, 1'b1);
    exp_rd("disabled_port", 1, 32'h0, 1'b0);

    // r0 ignores writes and bypass.
    step();
    wr(0, 0, 32'h1234);
    rd(0, 0);
    exp_rd("r0_bypass", 0, 32'h0, 1'b1);
    step();
    rd(0, 0);
    exp_rd("r0_array", 0, 32'h0, 1'b1);

    // Two ports hit r7: port 1 wins.
    step();
    wr(0, 7, 32'h11);
    wr(1, 7, 32'h22);
    rd(0, 7);
    exp_rd("dual_wr_bypass", 0, 32'h22, 1'b1);
    step();
    rd(1, 7);
    exp_rd("dual_wr_array", 1, 32'h22, 1'b1);

`ifdef REGFILE_SCOREBOARD_EN
    step();
    alloc(9);
    rd(0, 9);
    exp_rd("alloc_same_cycle", 0, 32'h0, 1'b1);
    exp_busy("busy_before_alloc", 32'h0);
    step();
    rd(0, 9);
    exp_rd("alloc_r9_stall", 0, 32'h0, 1'b0);
    exp_busy("alloc_r9_busy", 32'h0000_0200);
    step();
    wr(1, 9, 32'h55);
    rd(0, 9);
    rd(1, 9);
    exp_rd("wb_r9_bypass_p0", 0, 32'h55, 1'b1);
    exp_rd("wb_r9_bypass_p1", 1, 32'h55, 1'b1);
    exp_busy("wb_r9_busy_still", 32'h0000_0200);
    step();
    rd(0, 9);
    exp_rd("wb_r9_array", 0, 32'h55, 1'b1);
    exp_busy("wb_r9_cleared", 32'h0);
    step();
    alloc(9);
    wr(0, 9, 32'h66);
    step();
    alloc(9);
    rd(0, 9);
    exp_rd("alloc_wr_same_stall", 0, 32'h66, 1'b0);
    exp_busy("alloc_wr_same_busy", 32'h0000_0200);
    step();
    alloc(0);
    rd(0, 0);
    exp_rd("r0_always_ready", 0, 32'h0, 1'b1);
    exp_busy("realloc_keeps_busy", 32'h0000_0200);
    step();
    wr(0, 9, 32'h77);
    rd(0, 9);
    exp_rd("r9_final_wb", 0, 32'h77, 1'b1);
    exp_busy("alloc_r0_ignored", 32'h0000_0200);
    step();
    exp_busy("r9_final_clear", 32'h0);
`else
    step();
    alloc(9);
    step();
    rd(0, 9);
    exp_rd("nosb_ready", 0, 32'h0, 1'b1);
    exp_busy("nosb_busy", 32'h0);
`endif

    // Reset discards same-cycle write/alloc and clears busy.
    step();
    wr(0, 4, 32'h4444);
    wr(1, 2, 32'h2222);
    alloc(3);
    step();
    rd(0, 4);
    rd(1, 2);
    exp_rd("pre_reset_r4", 0, 32'h4444, 1'b1);
    exp_rd("pre_reset_r2", 1, 32'h2222, 1'b1);
`ifdef REGFILE_SCOREBOARD_EN
    exp_busy("pre_reset_busy", 32'h0000_0008);
`else
    exp_busy("pre_reset_busy", 32'h0);
`endif
    step();
    reset_n = 1'b0;
    wr(0, 4, 32'hABCD);
    alloc(3);
    step();
    reset_n = 1'b1;
    rd(0, 4);
    rd(1, 2);
    exp_rd("post_reset_r4", 0, 32'h0, 1'b1);
    exp_rd("post_reset_r2", 1, SP, 1'b1);
    exp_busy("post_reset_busy", 32'h0);
    step();
    rd(0, 5);
    rd(1, 7);
    exp_rd("post_reset_r5", 0, 32'h0, 1'b1);
    exp_rd("post_reset_r7", 1, 32'h0, 1'b1);
    step();

    waited = 0;
    while (q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left unchecked", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file, the successor to the core's single-write, two-read file. Provides NUM_RD combinational read ports and NUM_WR write ports with same-cycle write-to-read bypass. An optional per-register scoreboard tracks in-flight destinations so issue logic can stall on RAW hazards. It sits between decode/issue (reads, allocations) and writeback (writes).

## Interface
- XLEN, rapid_pkg::XLEN: data width.
- NUM_REGS, 32: architectural registers; power of two, ≥4.
- NUM_RD, 2: read ports, 1..4.
- NUM_WR, 1: write ports, 1..2.
- SP_RESET, rapid_pkg::RESET_STACK_POINTER: reset value of register 2.
- AW, $clog2(NUM_REGS): derived address width; not user-set.

Ports:
- i_clk  in  1  clock; all state updates on posedge.
- i_reset_n  in  1  reset; synchronous, active-low.
- i_rs_en  in  NUM_RD  per-port read enable.
- i_rs_addr  in  NUM_RD×AW  read addresses.
- o_rs_data  out  NUM_RD×XLEN  read data; 0 when the port is disabled.
- o_rs_ready  out  NUM_RD  operand valid: not busy, or bypassed this cycle.
- i_wr_en  in  NUM_WR  write enables.
- i_wr_addr  in  NUM_WR×AW  write addresses.
- i_wr_data  in  NUM_WR×XLEN  write data.
- i_alloc_en  in  1  mark a destination in-flight (scoreboard only).
- i_alloc_addr  in  AW  destination being allocated.
- o_busy  out  NUM_REGS  scoreboard vector; bit 0 always 0.

## Operation
- Register 0 reads 0 and ignores writes, allocations and bypass.
- Read port p, when i_rs_en[p]=1:
  - If any write port w has i_wr_en[w], i_wr_addr[w]==i_rs_addr[p] and the address is ≠0, return that i_wr_data (bypass).
  - Otherwise return the array entry.
- Read port p, when i_rs_en[p]=0: o_rs_data=0 and o_rs_ready=0. No tri-state anywhere.
- Two write ports to the same non-zero address in one cycle: the highest-index port wins, for both the array write and the bypass.
- Scoreboard:
  - i_alloc_en with address ≠0 sets busy[addr].
  - A write to addr clears busy[addr].
  - Alloc and write to the same address in one cycle leaves busy=1, because the new owner wins.
  - Allocating an already-busy register is legal and keeps it busy.
- o_rs_ready[p] = i_rs_en[p] && (!busy[addr] || bypass hit || addr==0).

## Timing
- Reads and bypass are combinational, with zero latency.
- Writes commit at the posedge and are visible from the array on the next cycle.
- Busy updates at the posedge. An alloc in cycle N shows busy in cycle N+1. A clearing write in cycle N gives ready=1 in cycle N through bypass, then from the array afterwards.
- Reset (i_reset_n=0 at a posedge):
  - All registers become 0, except register 2, which becomes SP_RESET.
  - All busy bits clear.
  - Writes and allocs in the same cycle are ignored.
  - Reset wins over any in-flight operation.
- Outputs during reset remain combinational views of the state. After the reset edge, o_busy=0 and reads return 0, or SP_RESET for register 2.

## Configuration
- REGFILE_SCOREBOARD_EN defined: the scoreboard is built, o_busy is driven, and i_alloc_* are honoured.
- REGFILE_SCOREBOARD_EN undefined:
  - No busy flops are built.
  - o_busy is tied to 0 and i_alloc_* are ignored.
  - o_rs_ready[p] = i_rs_en[p].

## Structure
- rapid_pkg holds XLEN, RESET_STACK_POINTER, and the typedef reg_addr_t (logic [AW-1:0] for 32 registers).
- The sub-module regfile_scoreboard (NUM_REGS, NUM_WR) holds the busy vector and its set/clear/reset logic. It is instantiated only under REGFILE_SCOREBOARD_EN.
- Bypass and priority muxing stay in regfile_mp.

## Test plan
- Reset, then read all registers: every register reads 0x0 except r2, which reads SP_RESET; o_busy=0.
- Write r5=0xDEADBEEF on port 0 while reading r5 in the same cycle: data is 0xDEADBEEF through bypass, and still 0xDEADBEEF from the array next cycle. Write r0=0x1234: r0 still reads 0.
- NUM_WR=2, both ports write r7 (0x11 on port 0, 0x22 on port 1): bypass and the next-cycle read both give 0x22.
- Scoreboard:
  - Alloc r9: busy[9]=1 next cycle and ready=0 on an r9 read.
  - Writeback r9=0x55: ready=1 with data 0x55 in the same cycle, busy[9]=0 after.
  - Alloc and write r9 in the same cycle: busy[9]=1.
- Alloc r3, write r4, then assert i_reset_n=0 for one cycle: all busy bits 0, r4 reads 0, and the write is discarded.
- Build without REGFILE_SCOREBOARD_EN, alloc r9: o_busy=0 and ready follows i_rs_en. A disabled port reads 0 with ready=0.
